mem_array_arbiter: RTL and testbench

// - Parametrised successor to the shared tristate memory-array bus.
// - Arbitrates NCHAN memory-interface channels onto one memory array and is its only driver, so no tristates.
// - Pipelined: accepts one command per cycle and returns read data tagged to the requesting channel.
// - Sits between the memory controllers and the single shared memory array.

---
 rtl/mem_array_arbiter_if.sv | 27 ++
 rtl/mem_array_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_array_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_array_arbiter_if.sv
// Channel-side bus of the memory-array arbiter: per-channel commands in,
// one-hot grants and tagged read data out.
interface mem_array_arbiter_if #(
    parameter int unsigned NCHAN     = 4,
    parameter int unsigned ADDRWIDTH = 12,
    parameter int unsigned BUSWIDTH  = 16
);
    logic [NCHAN-1:0]           req;
    logic [NCHAN-1:0]           we;
    logic [NCHAN*ADDRWIDTH-1:0] addr;
    logic [NCHAN*BUSWIDTH-1:0]  wdata;
    logic [NCHAN-1:0]           gnt;
    logic [NCHAN-1:0]           rdValid;
    logic [BUSWIDTH-1:0]        rdData;

    // Memory controllers drive commands.
    modport master (
        output req, we, addr, wdata,
        input  gnt, rdValid, rdData
    );

    // The arbiter accepts commands and returns read data.
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdValid, rdData
    );
endinterface

// File: rtl/mem_array_arbiter.sv
// Pipelined arbiter: grants one of NCHAN channels per cycle onto a single memory array
// and returns read data tagged with the requesting channel.
module mem_array_arbiter #(
    parameter int unsigned NCHAN      = 4,
    parameter int unsigned ADDRWIDTH  = 12,
    parameter int unsigned BUSWIDTH   = 16,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 en,
    mem_array_arbiter_if.slave   chan,
    output logic [ADDRWIDTH-1:0] arrAddr,
    output logic [BUSWIDTH-1:0]  arrDataIn,
    output logic                 arrRdEn,
    output logic                 arrWrEn,
    input  logic [BUSWIDTH-1:0]  arrDataOut
);
    localparam int unsigned IDW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic [IDW-1:0]                ptrQ;
    logic [IDW-1:0]                ptrD;
    logic [NCHAN-1:0]              gntD;
    logic [IDW-1:0]                gntIdx;
    logic                          gntAny;
    int                            searchIdx;
    logic                          selWe;
    logic [ADDRWIDTH-1:0]          selAddr;
    logic [BUSWIDTH-1:0]           selWdata;
    logic [RD_LATENCY:0]           tagValidQ;
    logic [RD_LATENCY:0][IDW-1:0]  tagChanQ;
    logic [NCHAN-1:0]              rdValidQ;
    logic [BUSWIDTH-1:0]           rdDataQ;

    // First requester found wins; round-robin starts the search at ptrQ.
    always_comb begin
        gntD      = '0;
        gntIdx    = '0;
        gntAny    = 1'b0;
        searchIdx = 0;
        if (en) begin
            for (int i = 0; i < int'(NCHAN); i++) begin
                if (ARB_MODE == 1) begin
                    searchIdx = i;
                end else begin
                    searchIdx = (int'(ptrQ) + i) % int'(NCHAN);
                end
                if (!gntAny && chan.req[IDW'(searchIdx)]) begin
                    gntAny = 1'b1;
                    gntIdx = IDW'(searchIdx);
                end
            end
        end
        if (gntAny) begin
            gntD[gntIdx] = 1'b1;
        end
    end

    always_comb begin
        ptrD = ptrQ;
        if (ARB_MODE == 0 && gntAny) begin
            ptrD = (gntIdx == IDW'(NCHAN - 1)) ? '0 : gntIdx + 1'b1;
        end
    end

    always_comb begin
        selWe    = 1'b0;
        selAddr  = '0;
        selWdata = '0;
        for (int k = 0; k < int'(NCHAN); k++) begin
            if (gntD[k]) begin
                selWe    = chan.we[k];
                selAddr  = chan.addr[k*ADDRWIDTH +: ADDRWIDTH];
                selWdata = chan.wdata[k*BUSWIDTH +: BUSWIDTH];
            end
        end
    end

    // Grant is combinational, but must stay low while the block is held in reset.
    assign chan.gnt = gntD & {NCHAN{resetN}};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ptrQ      <= '0;
            arrAddr   <= '0;
            arrDataIn <= '0;
            arrRdEn   <= 1'b0;
            arrWrEn   <= 1'b0;
        end else begin
            ptrQ    <= ptrD;
            arrRdEn <= gntAny & ~selWe;
            arrWrEn <= gntAny & selWe;
            if (gntAny) begin
                arrAddr <= selAddr;
                if (selWe) begin
                    arrDataIn <= selWdata;
                end
            end
        end
    end

    // Stage RD_LATENCY lines up with arrDataOut for the read issued RD_LATENCY cycles earlier.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tagValidQ <= '0;
            tagChanQ  <= '0;
        end else begin
            tagValidQ[0] <= gntAny & ~selWe;
            tagChanQ[0]  <= gntIdx;
            for (int i = 1; i <= int'(RD_LATENCY); i++) begin
                tagValidQ[i] <= tagValidQ[i-1];
                tagChanQ[i]  <= tagChanQ[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdValidQ <= '0;
            rdDataQ  <= '0;
        end else begin
            rdValidQ <= '0;
            if (tagValidQ[RD_LATENCY]) begin
                rdValidQ <= NCHAN'(1) << tagChanQ[RD_LATENCY];
                rdDataQ  <= arrDataOut;
            end
        end
    end

    assign chan.rdValid = rdValidQ;
    assign chan.rdData  = rdDataQ;

    gntOneHot: assert property (@(posedge clk) disable iff (!resetN) $onehot0(chan.gnt));
    strobesExclusive: assert property (@(posedge clk) disable iff (!resetN)
                                       !(arrRdEn && arrWrEn));
endmodule

// File: tb/tb_mem_array_arbiter.sv
// Scoreboard bench: dutA is round-robin with 1-cycle array latency, dutB is fixed
// priority with 2-cycle latency; each drives its own behavioural array.
module tb_mem_array_arbiter;
    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 12;
    localparam int unsigned BW  = 16;

    logic clk = 1'b0;
    logic resetN;
    logic en;
    int   cycle   = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    mem_array_arbiter_if #(.NCHAN(NCH), .ADDRWIDTH(AW), .BUSWIDTH(BW)) ifA ();
    mem_array_arbiter_if #(.NCHAN(NCH), .ADDRWIDTH(AW), .BUSWIDTH(BW)) ifB ();

    logic [AW-1:0] arrAddrA, arrAddrB;
    logic [BW-1:0] arrDataInA, arrDataInB, arrDataOutA, arrDataOutB, pipeB;
    logic          arrRdEnA, arrRdEnB, arrWrEnA, arrWrEnB;

    mem_array_arbiter #(
        .NCHAN(NCH), .ADDRWIDTH(AW), .BUSWIDTH(BW), .RD_LATENCY(1), .ARB_MODE(0)
    ) dutA (
        .clk(clk), .resetN(resetN), .en(en), .chan(ifA),
        .arrAddr(arrAddrA), .arrDataIn(arrDataInA), .arrRdEn(arrRdEnA),
        .arrWrEn(arrWrEnA), .arrDataOut(arrDataOutA)
    );

    mem_array_arbiter #(
        .NCHAN(NCH), .ADDRWIDTH(AW), .BUSWIDTH(BW), .RD_LATENCY(2), .ARB_MODE(1)
    ) dutB (
        .clk(clk), .resetN(resetN), .en(en), .chan(ifB),
        .arrAddr(arrAddrB), .arrDataIn(arrDataInB), .arrRdEn(arrRdEnB),
        .arrWrEn(arrWrEnB), .arrDataOut(arrDataOutB)
    );

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } strbT;

    typedef struct {
        logic [NCH-1:0] vld;
        logic [BW-1:0]  data;
        int             due;
    } rdExpT;

    logic [BW-1:0] memA [logic [AW-1:0]];
    logic [BW-1:0] memB [logic [AW-1:0]];
    logic [BW-1:0] refA [logic [AW-1:0]];
    logic [BW-1:0] refB [logic [AW-1:0]];
    strbT          strbA [int];
    strbT          strbB [int];
    rdExpT         rdQA [$];
    rdExpT         rdQB [$];

    // Unwritten locations hold a fixed address-derived pattern.
    function automatic logic [BW-1:0] pat(input logic [AW-1:0] a);
        return {4'h5, a} ^ 16'h0F0F;
    endfunction

    function automatic logic [BW-1:0] refRead(input int d, input logic [AW-1:0] a);
        if (d == 0) return refA.exists(a) ? refA[a] : pat(a);
        return refB.exists(a) ? refB[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (arrWrEnA === 1'b1) memA[arrAddrA] = arrDataInA;
        if (arrRdEnA === 1'b1) arrDataOutA <= memA.exists(arrAddrA) ? memA[arrAddrA] : pat(arrAddrA);
    end

    always @(posedge clk) begin
        if (arrWrEnB === 1'b1) memB[arrAddrB] = arrDataInB;
        if (arrRdEnB === 1'b1) pipeB <= memB.exists(arrAddrB) ? memB[arrAddrB] : pat(arrAddrB);
        else pipeB <= 16'hDEAD;
        arrDataOutB <= pipeB;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic setChan(input int d, input int k, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [BW-1:0] dat);
        if (d == 0) begin
            ifA.req[k] = r;
            ifA.we[k] = w;
            ifA.addr[k*AW +: AW] = a;
            ifA.wdata[k*BW +: BW] = dat;
        end else begin
            ifB.req[k] = r;
            ifB.we[k] = w;
            ifB.addr[k*AW +: AW] = a;
            ifB.wdata[k*BW +: BW] = dat;
        end
    endtask

    // Record the effects of an expected grant in cycle 'cycle'.
    task automatic issue(input int d, input logic [NCH-1:0] g);
        int k = 0;
        logic w;
        logic [AW-1:0] a;
        logic [BW-1:0] dat;
        strbT s;
        rdExpT r;
        for (int i = 0; i < NCH; i++) if (g[i]) k = i;
        if (d == 0) begin
            w = ifA.we[k];
            a = ifA.addr[k*AW +: AW];
            dat = ifA.wdata[k*BW +: BW];
        end else begin
            w = ifB.we[k];
            a = ifB.addr[k*AW +: AW];
            dat = ifB.wdata[k*BW +: BW];
        end
        if (w) begin
            s = '{rd: 1'b0, wr: 1'b1, addr: a, data: dat};
            if (d == 0) refA[a] = dat;
            else refB[a] = dat;
        end else begin
            s = '{rd: 1'b1, wr: 1'b0, addr: a, data: '0};
            r = '{vld: g, data: refRead(d, a), due: cycle + 2 + ((d == 0) ? 1 : 2)};
            if (d == 0) rdQA.push_back(r);
            else rdQB.push_back(r);
        end
        if (d == 0) strbA[cycle + 1] = s;
        else strbB[cycle + 1] = s;
    endtask

    task automatic step(input logic [NCH-1:0] expA, input logic [NCH-1:0] expB);
        @(negedge clk);
        checkVal("gntA", ifA.gnt, expA);
        checkVal("gntB", ifB.gnt, expB);
        if (expA != '0) issue(0, expA);
        if (expB != '0) issue(1, expB);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor(input int d);
        logic rdEn, wrEn, have;
        logic [AW-1:0] a;
        logic [BW-1:0] din, rdat;
        logic [NCH-1:0] v;
        strbT s;
        rdExpT r;
        int qn;
        string n;
        n = (d == 0) ? "A" : "B";
        if (d == 0) begin
            rdEn = arrRdEnA; wrEn = arrWrEnA; a = arrAddrA; din = arrDataInA;
            v = ifA.rdValid; rdat = ifA.rdData; qn = rdQA.size();
            have = strbA.exists(cycle);
            if (have) begin s = strbA[cycle]; strbA.delete(cycle); end
        end else begin
            rdEn = arrRdEnB; wrEn = arrWrEnB; a = arrAddrB; din = arrDataInB;
            v = ifB.rdValid; rdat = ifB.rdData; qn = rdQB.size();
            have = strbB.exists(cycle);
            if (have) begin s = strbB[cycle]; strbB.delete(cycle); end
        end
        if (have) begin
            checkVal({"arrRdEn", n}, rdEn, s.rd);
            checkVal({"arrWrEn", n}, wrEn, s.wr);
            checkVal({"arrAddr", n}, a, s.addr);
            if (s.wr) checkVal({"arrDataIn", n}, din, s.data);
        end else begin
            checkVal({"arrRdEnIdle", n}, rdEn, 0);
            checkVal({"arrWrEnIdle", n}, wrEn, 0);
        end
        if (v != '0) begin
            if (qn == 0) begin
                checkVal({"rdValidUnexpected", n}, v, 0);
            end else begin
                r = (d == 0) ? rdQA.pop_front() : rdQB.pop_front();
                checkVal({"rdValid", n}, v, r.vld);
                checkVal({"rdData", n}, rdat, r.data);
                checkVal({"rdCycle", n}, cycle, r.due);
            end
        end else if (qn != 0) begin
            r = (d == 0) ? rdQA[0] : rdQB[0];
            if (r.due <= cycle) begin
                if (d == 0) void'(rdQA.pop_front());
                else void'(rdQB.pop_front());
                checkVal({"rdMissing", n}, v, r.vld);
            end
        end
    endtask

    always @(negedge clk) begin
        if (resetN === 1'b1) begin
            monitor(0);
            monitor(1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b1;
        en = 1'b1;
        ifA.req = '0; ifA.we = '0; ifA.addr = '0; ifA.wdata = '0;
        ifB.req = '0; ifB.we = '0; ifB.addr = '0; ifB.wdata = '0;
        #2 resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rstArrRdEnA", arrRdEnA, 0);
        checkVal("rstArrWrEnA", arrWrEnA, 0);
        checkVal("rstArrAddrA", arrAddrA, 0);
        checkVal("rstArrDataInA", arrDataInA, 0);
        checkVal("rstRdValidA", ifA.rdValid, 0);
        checkVal("rstRdDataA", ifA.rdData, 0);
        checkVal("rstArrRdEnB", arrRdEnB, 0);
        checkVal("rstRdValidB", ifB.rdValid, 0);
        resetN = 1'b1;

        // ch2 writes then reads the same address.
        setChan(0, 2, 1'b1, 1'b1, 12'h055, 16'hBEEF);
        step(4'b0100, 4'b0000);
        setChan(0, 2, 1'b1, 1'b0, 12'h055, 16'h0000);
        step(4'b0100, 4'b0000);
        setChan(0, 2, 1'b0, 1'b0, 12'h000, 16'h0000);
        repeat (4) step(4'b0000, 4'b0000);
        checkVal("arrAddrHoldA", arrAddrA, 12'h055);

        // Reset asserted while reads are in flight.
        for (int k = 0; k < NCH; k++) setChan(0, k, 1'b1, 1'b0, AW'(12'h300 + k), 16'h0000);
        step(4'b1000, 4'b0000);
        step(4'b0001, 4'b0000);
        resetN = 1'b0;
        #1;
        checkVal("midRstArrRdEnA", arrRdEnA, 0);
        checkVal("midRstArrWrEnA", arrWrEnA, 0);
        checkVal("midRstRdValidA", ifA.rdValid, 0);
        checkVal("midRstGntA", ifA.gnt, 0);
        rdQA.delete(); rdQB.delete(); strbA.delete(); strbB.delete();
        repeat (2) step(4'b0000, 4'b0000);

        // All four channels request continuously: writes first, then reads of a neighbour.
        for (int k = 0; k < NCH; k++)
            setChan(0, k, 1'b1, 1'b1, AW'(12'h100 + k), BW'(16'hA000 + k));
        resetN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int g;
            g = i % NCH;
            step(NCH'(1) << g, 4'b0000);
            if (i < NCH) setChan(0, g, 1'b1, 1'b0, AW'(12'h100 + ((g + 1) % NCH)), 16'h0000);
            else setChan(0, g, 1'b0, 1'b0, 12'h000, 16'h0000);
        end
        repeat (4) step(4'b0000, 4'b0000);

        // en low holds off pending requests; the outstanding read still returns.
        setChan(0, 1, 1'b1, 1'b0, 12'h102, 16'h0000);
        step(4'b0010, 4'b0000);
        setChan(0, 1, 1'b0, 1'b0, 12'h000, 16'h0000);
        en = 1'b0;
        setChan(0, 0, 1'b1, 1'b0, 12'h103, 16'h0000);
        setChan(0, 3, 1'b1, 1'b0, 12'h055, 16'h0000);
        repeat (3) step(4'b0000, 4'b0000);
        en = 1'b1;
        step(4'b1000, 4'b0000);
        setChan(0, 3, 1'b0, 1'b0, 12'h000, 16'h0000);
        step(4'b0001, 4'b0000);
        setChan(0, 0, 1'b0, 1'b0, 12'h000, 16'h0000);
        repeat (4) step(4'b0000, 4'b0000);

        // Fixed priority: ch1 keeps winning until it drops, then ch3.
        setChan(1, 1, 1'b1, 1'b1, 12'h200, 16'hC000);
        setChan(1, 3, 1'b1, 1'b0, 12'h201, 16'h0000);
        for (int j = 0; j < 3; j++) begin
            step(4'b0000, 4'b0010);
            if (j < 2) setChan(1, 1, 1'b1, 1'b1, AW'(12'h201 + j), BW'(16'hC001 + j));
            else setChan(1, 1, 1'b0, 1'b0, 12'h000, 16'h0000);
        end
        step(4'b0000, 4'b1000);
        setChan(1, 3, 1'b0, 1'b0, 12'h000, 16'h0000);

        // Back-to-back reads from ch0, ch3, ch1 with 2-cycle array latency.
        setChan(1, 0, 1'b1, 1'b0, 12'h010, 16'h0000);
        step(4'b0000, 4'b0001);
        setChan(1, 0, 1'b0, 1'b0, 12'h000, 16'h0000);
        setChan(1, 3, 1'b1, 1'b0, 12'h020, 16'h0000);
        step(4'b0000, 4'b1000);
        setChan(1, 3, 1'b0, 1'b0, 12'h000, 16'h0000);
        setChan(1, 1, 1'b1, 1'b0, 12'h030, 16'h0000);
        step(4'b0000, 4'b0010);
        setChan(1, 1, 1'b0, 1'b0, 12'h000, 16'h0000);
        repeat (6) step(4'b0000, 4'b0000);

        checkVal("pendingReadsA", rdQA.size(), 0);
        checkVal("pendingReadsB", rdQB.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
